// File: rtl/trigger_scheduler_pkg.sv
// rtl/trigger_scheduler_pkg.sv - shared FSM state type and ID-width helper for the trigger scheduler
package trigger_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trigger_scheduler_rr_arbiter.sv
// rtl/trigger_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr+1 with wrap
module trigger_scheduler_rr_arbiter
    import trigger_scheduler_pkg::*;
#(
    parameter int  N    = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_gnt_valid,
    output logic [ID_W-1:0] o_gnt_id
);

    logic [ID_W-1:0] w_idx;

    // Scan farthest offset first so the nearest requester after ptr is the last write.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = '0;
        w_idx       = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = w_idx;
            end
        end
    end

endmodule

// File: rtl/trigger_scheduler.sv
// rtl/trigger_scheduler.sv - shares one single-shot resource among N_REQ trigger sources with hold-off
// Optional macro TRIG_SYNC_EN adds a 2-flop synchronizer on each trigger input.
module trigger_scheduler
    import trigger_scheduler_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  HOLDOFF_W = 8,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_trig_in,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    input  logic                 i_res_done,
    input  logic                 i_ovr_clr,
    output logic                 o_fire,
    output logic [ID_W-1:0]      o_fire_id,
    output logic                 o_busy,
    output logic [N_REQ-1:0]     o_pending,
    output logic [N_REQ-1:0]     o_overrun
);

    state_t               r_state, w_next_state;
    logic [N_REQ-1:0]     w_trig, r_last_trig, w_edge, w_gnt_mask;
    logic [N_REQ-1:0]     r_pending, r_overrun;
    logic [ID_W-1:0]      r_ptr, w_gnt_id, r_fire_id;
    logic                 w_gnt_valid, w_grant, w_hold_load;
    logic                 r_fire, r_busy;
    logic [HOLDOFF_W-1:0] r_cnt, w_cnt_next;

`ifdef TRIG_SYNC_EN
    logic [N_REQ-1:0] r_sync1, r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_trig_in;
            r_sync2 <= r_sync1;
        end
    end
    assign w_trig = r_sync2;
`else
    assign w_trig = i_trig_in;
`endif

    assign w_edge = w_trig & ~r_last_trig;

    trigger_scheduler_rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req       (r_pending),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_gnt_valid) w_next_state = S_FIRE;
            S_FIRE, S_WAIT: begin
                if (i_res_done) w_next_state = (i_holdoff == '0) ? S_IDLE : S_HOLD;
                else            w_next_state = S_WAIT;
            end
            S_HOLD: if (r_cnt == '0) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant     = (r_state == S_IDLE) && w_gnt_valid;
        w_hold_load = (w_next_state == S_HOLD) && (r_state != S_HOLD);
        w_gnt_mask  = w_grant ? (N_REQ'(1) << w_gnt_id) : '0;
        w_cnt_next  = r_cnt;
        if (w_hold_load)
            w_cnt_next = i_holdoff - HOLDOFF_W'(1);
        else if ((r_state == S_HOLD) && (r_cnt != '0))
            w_cnt_next = r_cnt - HOLDOFF_W'(1);
    end

    // A new edge on the channel being granted re-arms it rather than counting as overrun.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_trig <= '1;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_fire      <= 1'b0;
            r_fire_id   <= '0;
            r_busy      <= 1'b0;
            r_pending   <= '0;
            r_overrun   <= '0;
            r_cnt       <= '0;
        end else begin
            r_last_trig <= w_trig;
            r_fire      <= w_grant;
            r_busy      <= (w_next_state != S_IDLE);
            r_cnt       <= w_cnt_next;
            r_pending   <= (r_pending & ~w_gnt_mask) | w_edge;
            r_overrun   <= (i_ovr_clr ? '0 : r_overrun) | (w_edge & r_pending & ~w_gnt_mask);
            if (w_grant) begin
                r_ptr     <= w_gnt_id;
                r_fire_id <= w_gnt_id;
            end
        end
    end

    assign o_fire    = r_fire;
    assign o_fire_id = r_fire_id;
    assign o_busy    = r_busy;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_trigger_scheduler.sv
// tb/tb_trigger_scheduler.sv - directed self-checking bench for trigger_scheduler
module tb_trigger_scheduler;

`ifdef TRIG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       i_rst, i_res_done, i_ovr_clr;
    logic [3:0] i_trig_in;
    logic [7:0] i_holdoff;
    logic       fire, busy;
    logic [1:0] fire_id;
    logic [3:0] pending, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int res_lat  = 1;
    int done_cd  = -1;
    int c0;
    int fire_cyc[$];
    int fire_ids[$];
    int fire_pend[$];
    int exp_pend[4] = '{14, 12, 8, 0};

    trigger_scheduler #(.N_REQ(4), .HOLDOFF_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_trig_in  (i_trig_in),
        .i_holdoff  (i_holdoff),
        .i_res_done (i_res_done),
        .i_ovr_clr  (i_ovr_clr),
        .o_fire     (fire),
        .o_fire_id  (fire_id),
        .o_busy     (busy),
        .o_pending  (pending),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; logs fire pulses and plays the resource, answering res_lat cycles after fire.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        i_res_done = 1'b0;
        if (fire) begin
            fire_cyc.push_back(cyc);
            fire_ids.push_back(int'(fire_id));
            fire_pend.push_back(int'(pending));
            done_cd = res_lat;
        end else if (done_cd > 0) begin
            done_cd--;
        end
        if (done_cd == 0) begin
            i_res_done = 1'b1;
            done_cd    = -1;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic clear_log();
        fire_cyc.delete();
        fire_ids.delete();
        fire_pend.delete();
        busy_cnt = 0;
    endtask

    task automatic assert_reset();
        i_rst      = 1'b1;
        i_res_done = 1'b0;
        i_ovr_clr  = 1'b0;
        done_cd    = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        tick();
        tick();
        clear_log();
    endtask

    initial begin
        i_rst = 1'b1; i_trig_in = '0; i_holdoff = '0; i_res_done = 1'b0; i_ovr_clr = 1'b0;
        assert_reset();
        check("rst_fire", fire, 0);
        check("rst_fire_id", fire_id, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 0);
        release_reset();

        // Single held trigger on channel 2
        res_lat = 3; i_holdoff = 8'd0; c0 = cyc;
        i_trig_in = 4'b0100;
        repeat (20) tick();
        i_trig_in = 4'b0000;
        repeat (4) tick();
        check("t1_nfire", fire_cyc.size(), 1);
        if (fire_cyc.size() >= 1) begin
            check("t1_latency", fire_cyc[0] - c0, 2 + SYNC_LAT);
            check("t1_id", fire_ids[0], 2);
        end
        check("t1_busy_cycles", busy_cnt, 4);

        // All four rise together
        assert_reset(); release_reset();
        res_lat = 1; c0 = cyc;
        i_trig_in = 4'b1111;
        repeat (20) tick();
        i_trig_in = 4'b0000;
        check("t2_nfire", fire_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < fire_cyc.size()) begin
                check($sformatf("t2_id%0d", i), fire_ids[i], i);
                check($sformatf("t2_cyc%0d", i), fire_cyc[i] - c0, 2 + SYNC_LAT + 3 * i);
                check($sformatf("t2_pend%0d", i), fire_pend[i], exp_pend[i]);
            end
        end
        check("t2_pending_end", pending, 0);

        // Hold-off of 5 between two channels
        assert_reset(); release_reset();
        res_lat = 1; i_holdoff = 8'd5; c0 = cyc;
        i_trig_in = 4'b0011;
        repeat (30) tick();
        check("t3_nfire", fire_cyc.size(), 2);
        if (fire_cyc.size() >= 2) begin
            check("t3_first", fire_cyc[0] - c0, 2 + SYNC_LAT);
            check("t3_spacing", fire_cyc[1] - fire_cyc[0], 8);
            check("t3_id1", fire_ids[1], 1);
        end
        check("t3_busy_cycles", busy_cnt, 14);

        // Overrun on channel 1 while channel 0 waits
        assert_reset(); i_trig_in = 4'b0000; release_reset();
        res_lat = 10; i_holdoff = 8'd0;
        i_trig_in = 4'b0001;
        repeat (3) tick();
        i_trig_in = 4'b0011; tick();
        i_trig_in = 4'b0001; tick();
        i_trig_in = 4'b0011; tick();
        i_trig_in = 4'b0001; tick();
        repeat (SYNC_LAT) tick();
        check("t4_overrun", overrun, 4'b0010);
        check("t4_pending", pending, 4'b0010);
        check("t4_busy", busy, 1);
        i_ovr_clr = 1'b1; tick();
        i_ovr_clr = 1'b0;
        check("t4_overrun_clr", overrun, 0);
        check("t4_pending_kept", pending, 4'b0010);
        repeat (20) tick();
        check("t4_nfire", fire_cyc.size(), 2);
        if (fire_cyc.size() >= 2) check("t4_id1", fire_ids[1], 1);

        // Level held through reset, then async reset mid-WAIT
        i_trig_in = 4'b0001;
        assert_reset(); release_reset();
        repeat (10) tick();
        check("t5_no_fire", fire_cyc.size(), 0);
        check("t5_no_pending", pending, 0);
        res_lat = 20;
        i_trig_in = 4'b0101;
        repeat (5) tick();
        i_trig_in = 4'b1101;
        repeat (2) tick();
        repeat (SYNC_LAT) tick();
        check("t5_busy_wait", busy, 1);
        check("t5_fire_id", fire_id, 2);
        check("t5_pending", pending, 4'b1000);
        #3;
        i_rst = 1'b1;
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_fire_id", fire_id, 0);
        check("t5_async_pending", pending, 0);
        done_cd = -1; i_res_done = 1'b0;

        // Completion in the FIRE cycle
        i_trig_in = 4'b0000;
        release_reset();
        res_lat = 0; i_holdoff = 8'd0; c0 = cyc;
        i_trig_in = 4'b0011;
        repeat (10) tick();
        check("t6_nfire", fire_cyc.size(), 2);
        if (fire_cyc.size() >= 2) begin
            check("t6_spacing", fire_cyc[1] - fire_cyc[0], 2);
            check("t6_id1", fire_ids[1], 1);
        end
        check("t6_busy_cycles", busy_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_scheduler.md
Name: trigger_scheduler

Overview:
- Shares one downstream single-shot resource between N_REQ independent trigger sources (e.g. a pulser or capture engine).
- Each source's rising edges become single-cycle requests that are latched as pending.
- A round-robin arbiter fires the resource for one channel at a time.
- After each firing the block waits for completion, then applies a programmable hold-off before the next firing.

Parameters:
N_REQ, 4, number of trigger sources (2..16)
HOLDOFF_W, 8, width of hold-off counter/input
ID_W, $clog2(N_REQ), width of fire_id (derived, not overridable)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
trig_in  in  N_REQ  per-source trigger levels, any duration
holdoff  in  HOLDOFF_W  idle cycles enforced after each completion
res_done  in  1  single-cycle completion pulse from the resource
ovr_clr  in  1  single-cycle clear of the overrun flags
fire  out  1  single-cycle start pulse to the resource
fire_id  out  ID_W  channel being served; valid while busy
busy  out  1  high whenever state != IDLE
pending  out  N_REQ  latched, not-yet-served requests
overrun  out  N_REQ  sticky: an edge arrived while that channel was already pending

Behaviour:
- Reset (async, while rst high):
  - state=IDLE; fire=0, fire_id=0, busy=0, pending=0, overrun=0.
  - last_trig=all ones, so a level held high through reset generates no request.
  - RR pointer=N_REQ-1, so channel 0 has first priority.
- Edge detect: edge[i] = trig_in[i] & ~last_trig[i], evaluated each posedge; last_trig <= trig_in.
- Pending:
  - Bit set on edge.
  - Bit cleared on the edge where that channel is granted.
  - If edge and grant coincide on the same channel, the bit stays set and no overrun is flagged.
  - Edge while the bit is already set and not being granted: overrun[i] <= 1.
  - ovr_clr clears all overrun bits. A same-cycle new overrun wins over the clear.
- Arbiter:
  - Round-robin over pending, searching from ptr+1 upward with wrap.
  - ptr <= granted id on grant.
- FSM states IDLE, FIRE, WAIT, HOLD:
  - IDLE: if pending != 0 → FIRE; fire<=1, fire_id<=grant, clear pending[grant].
  - FIRE (exactly 1 cycle, fire high): res_done sampled high → HOLD (or IDLE if holdoff==0), else → WAIT. fire<=0.
  - WAIT: stay until res_done; then load cnt<=holdoff-1 and → HOLD, or → IDLE if holdoff==0. No timeout.
  - HOLD: cnt decrements each cycle; → IDLE when cnt==0. holdoff is sampled only at HOLD entry.
  - res_done in IDLE or HOLD is ignored.
- Latency: trig_in rise sampled at edge k → pending set after k → fire high in the cycle after k+1 (2 cycles) when idle.
- Minimum spacing between fire pulses: 2 + resource latency + holdoff cycles.
- busy is registered from state. fire_id holds its value after completion until the next grant.

Optional Feature:
TRIG_SYNC_EN
- Defined: each trig_in bit passes through a 2-flop synchronizer, reset to 1, before edge detection. Edge-to-fire latency becomes 4 cycles.
- Undefined: trig_in is used directly and must be synchronous to clk.

Decomposition:
- trigger_scheduler_pkg: state enum (IDLE, FIRE, WAIT, HOLD) and ID-width helper function.
- One sub-module, rr_arbiter (N param):
  - Inputs: req, ptr.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational rotate-and-priority-encode.

Test Plan:
1. trig_in[2] rises once and is held high 20 cycles, holdoff=0, res_done 3 cycles after fire → exactly one fire with fire_id=2, 2 cycles after the rise; busy high 4 cycles; no second fire.
2. trig_in 4'b1111 all rise together, res_done 1 cycle after each fire, holdoff=0 → fires with ids 0,1,2,3 in order; pending decrements to 0.
3. holdoff=5, two pending channels → the second fire occurs exactly 5 cycles after the first res_done plus 1 IDLE cycle; busy stays high through HOLD.
4. Channel 1 pulses twice while served channel 0 is in WAIT → overrun=4'b0010, pending[1]=1; ovr_clr → overrun=0.
5. trig_in=4'b0001 held through reset release → no fire. Assert rst while in WAIT → outputs return to reset values immediately, asynchronously.
6. res_done asserted in the FIRE cycle, holdoff=0 → FSM goes FIRE→IDLE, and a pending channel fires 1 cycle later.
